// File: rtl/dec_queue.sv
// Decoupled RV32I decode stage: instructions are decoded on accept and buffered in a
// DEPTH-entry queue. Defining DEC_ILLEGAL_CHK_EN adds per-entry illegal-instruction tagging.
module dec_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       flush,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [XLEN-1:0]            out_pc,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [31:0]                out_imm,
    output logic                       out_rs1_ren,
    output logic                       out_rs2_ren,
    output logic                       out_rd_wen,
`ifdef DEC_ILLEGAL_CHK_EN
    output logic                       out_illegal,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcSystem  = 7'b1110011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [31:0]     imm;
        logic            rs1_ren;
        logic            rs2_ren;
        logic            rd_wen;
`ifdef DEC_ILLEGAL_CHK_EN
        logic            illegal;
`endif
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            dec_entry;
    entry_t            head;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [6:0]        dec_opc;
    logic              push;
    logic              pop;

    assign dec_opc = in_inst[6:0];

`ifdef DEC_ILLEGAL_CHK_EN
    logic dec_known;
    logic dec_illegal;

    always_comb begin
        dec_known = 1'b0;
        case (dec_opc)
            OpcOp, OpcOpImm, OpcJalr, OpcLoad, OpcSystem, OpcStore,
            OpcBranch, OpcLui, OpcAuipc, OpcJal, OpcMiscMem: dec_known = 1'b1;
            default: dec_known = 1'b0;
        endcase
    end

    // Only base-ISA funct7 values are legal for register-register ops.
    assign dec_illegal = ~dec_known | (in_inst[1:0] != 2'b11) |
                         ((dec_opc == OpcOp) & (in_inst[31:25] != 7'h00) &
                          (in_inst[31:25] != 7'h20));
`endif

    always_comb begin
        dec_entry      = '0;
        dec_entry.inst = in_inst;
        dec_entry.pc   = in_pc;
        case (dec_opc)
            OpcOp: begin
                dec_entry.rs1_ren = 1'b1;
                dec_entry.rs2_ren = 1'b1;
                dec_entry.rd_wen  = 1'b1;
            end
            OpcOpImm, OpcJalr, OpcLoad, OpcSystem: begin
                dec_entry.imm     = {{20{in_inst[31]}}, in_inst[31:20]};
                dec_entry.rs1_ren = 1'b1;
                dec_entry.rd_wen  = 1'b1;
            end
            OpcStore: begin
                dec_entry.imm     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                dec_entry.rs1_ren = 1'b1;
                dec_entry.rs2_ren = 1'b1;
            end
            OpcBranch: begin
                dec_entry.imm     = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                     in_inst[30:25], in_inst[11:8], 1'b0};
                dec_entry.rs1_ren = 1'b1;
                dec_entry.rs2_ren = 1'b1;
            end
            OpcLui, OpcAuipc: begin
                dec_entry.imm    = {in_inst[31:12], 12'b0};
                dec_entry.rd_wen = 1'b1;
            end
            OpcJal: begin
                dec_entry.imm    = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                    in_inst[20], in_inst[30:21], 1'b0};
                dec_entry.rd_wen = 1'b1;
            end
            default: ;
        endcase

        // x0 is hardwired, so a write to it is never a real write.
        if (in_inst[11:7] == 5'd0) begin
            dec_entry.rd_wen = 1'b0;
        end

`ifdef DEC_ILLEGAL_CHK_EN
        dec_entry.illegal = dec_illegal;
        if (dec_illegal) begin
            dec_entry.rs1_ren = 1'b0;
            dec_entry.rs2_ren = 1'b0;
            dec_entry.rd_wen  = 1'b0;
        end
`endif
    end

    assign in_rdy  = (count_q != CntW'(DEPTH)) & ~flush;
    assign out_vld = (count_q != '0);
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= dec_entry;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_pc      = head.pc;
    assign out_opcode  = head.inst[6:0];
    assign out_rd      = head.inst[11:7];
    assign out_funct3  = head.inst[14:12];
    assign out_rs1     = head.inst[19:15];
    assign out_rs2     = head.inst[24:20];
    assign out_funct7  = head.inst[31:25];
    assign out_imm     = head.imm;
    assign out_rs1_ren = head.rs1_ren;
    assign out_rs2_ren = head.rs2_ren;
    assign out_rd_wen  = head.rd_wen;
`ifdef DEC_ILLEGAL_CHK_EN
    assign out_illegal = head.illegal;
`endif
    assign count       = count_q;

endmodule

// File: tb/tb_dec_queue.sv
// Self-checking bench for dec_queue: directed decode vectors, full/flush/reset cases and a
// randomized run against a queue-based reference model.
module tb_dec_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef DEC_ILLEGAL_CHK_EN
    localparam int unsigned BW    = XLEN + 68;
`else
    localparam int unsigned BW    = XLEN + 67;
`endif

    logic            CLK = 1'b0;
    logic            RSTN = 1'b0;
    logic            flush = 1'b0;
    logic            in_vld = 1'b0;
    logic            in_rdy;
    logic [31:0]     in_inst = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_vld;
    logic            out_rdy = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [31:0]     out_imm;
    logic            out_rs1_ren;
    logic            out_rs2_ren;
    logic            out_rd_wen;
    logic [CW-1:0]   count;
    logic [BW-1:0]   obs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN+31:0] model_q [$];

    always #5 CLK = ~CLK;

`ifdef DEC_ILLEGAL_CHK_EN
    logic out_illegal;
    assign obs = {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                  out_imm, out_rs1_ren, out_rs2_ren, out_rd_wen, out_illegal};
`else
    assign obs = {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                  out_imm, out_rs1_ren, out_rs2_ren, out_rd_wen};
`endif

    dec_queue #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .flush       (flush),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_rs1_ren (out_rs1_ren),
        .out_rs2_ren (out_rs2_ren),
        .out_rd_wen  (out_rd_wen),
`ifdef DEC_ILLEGAL_CHK_EN
        .out_illegal (out_illegal),
`endif
        .count       (count)
    );

    // Reference decode straight from the instruction-format table.
    function automatic logic [BW-1:0] ref_bundle(input logic [XLEN-1:0] pc,
                                                 input logic [31:0] inst);
        logic [6:0]  op = inst[6:0];
        logic [31:0] imm = 32'd0;
        logic        r1 = 1'b0, r2 = 1'b0, w = 1'b0;
        logic        ill;
        case (op)
            7'b0110011: begin r1 = 1; r2 = 1; w = 1; end
            7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011: begin
                imm = 32'($signed(inst[31:20])); r1 = 1; w = 1;
            end
            7'b0100011: begin
                imm = 32'($signed({inst[31:25], inst[11:7]})); r1 = 1; r2 = 1;
            end
            7'b1100011: begin
                imm = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                r1 = 1; r2 = 1;
            end
            7'b0110111, 7'b0010111: begin imm = inst & 32'hFFFF_F000; w = 1; end
            7'b1101111: begin
                imm = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                w = 1;
            end
            default: ;
        endcase
        if (inst[11:7] == 5'd0) w = 0;
        ill = !(op inside {7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011,
                           7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                           7'b0001111})
              || (inst[1:0] != 2'b11)
              || (op == 7'b0110011 && !(inst[31:25] inside {7'h00, 7'h20}));
`ifdef DEC_ILLEGAL_CHK_EN
        if (ill) begin r1 = 0; r2 = 0; w = 0; end
        return {pc, op, inst[11:7], inst[19:15], inst[24:20], inst[14:12], inst[31:25],
                imm, r1, r2, w, ill};
`else
        return {pc, op, inst[11:7], inst[19:15], inst[24:20], inst[14:12], inst[31:25],
                imm, r1, r2, w};
`endif
    endfunction

    logic [6:0] opc_tab [11] = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011,
                                 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b0001111};

    function automatic logic [31:0] rand_inst();
        logic [31:0] r = $urandom();
        int k = $urandom_range(0, 12);
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        if (k >= 11) return r;
        return {r[31:7], opc_tab[k]};
    endfunction

    logic [31:0] v_inst [8] = '{32'h0050_0093, 32'h0020_A423, 32'hFE00_0EE3, 32'h1234_52B7,
                                32'h0000_0013, 32'h0080_00EF, 32'h0000_000F, 32'h0020_81B3};
    logic [31:0] v_imm  [8] = '{32'h0000_0005, 32'h0000_0008, 32'hFFFF_FFFC, 32'h1234_5000,
                                32'h0000_0000, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000};
    logic [2:0]  v_en   [8] = '{3'b101, 3'b110, 3'b110, 3'b001, 3'b100, 3'b001, 3'b000, 3'b111};

    task automatic test_reset();
        #12;
        n_checks++;
        if ({out_vld, in_rdy, count} !== {1'b0, 1'b1, CW'(0)}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got vld/rdy/count %b/%b/%0d, want 0/1/0",
                     out_vld, in_rdy, count);
        end
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h, want 0", obs);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({out_vld, in_rdy, count} !== {1'b0, 1'b1, CW'(0)}) begin
            n_fail++;
            $display("FAIL post_reset_ctrl: got %b/%b/%0d, want 0/1/0", out_vld, in_rdy, count);
        end
    endtask

    task automatic test_decode();
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_vld  = 1'b1;
            in_inst = v_inst[k];
            in_pc   = XLEN'(32'h1000 + 4 * k);
            @(negedge CLK);
            in_vld = 1'b0;
            n_checks++;
            if ({out_vld, count} !== {1'b1, CW'(1)}) begin
                n_fail++;
                $display("FAIL dec_vld[%0d]: got vld/count %b/%0d, want 1/1", k, out_vld, count);
            end
            n_checks++;
            if ({out_imm, out_rs1_ren, out_rs2_ren, out_rd_wen} !== {v_imm[k], v_en[k]}) begin
                n_fail++;
                $display("FAIL dec_imm_en[%0d]: got %h/%b%b%b, want %h/%b", k, out_imm,
                         out_rs1_ren, out_rs2_ren, out_rd_wen, v_imm[k], v_en[k]);
            end
            n_checks++;
            if (obs !== ref_bundle(XLEN'(32'h1000 + 4 * k), v_inst[k])) begin
                n_fail++;
                $display("FAIL dec_fields[%0d]: got %h, want %h", k, obs,
                         ref_bundle(XLEN'(32'h1000 + 4 * k), v_inst[k]));
            end
            if (k == 0) begin
                n_checks++;
                if ({out_rd, out_rs1} !== {5'd1, 5'd0}) begin
                    n_fail++;
                    $display("FAIL addi_regs: got rd=%0d rs1=%0d, want rd=1 rs1=0",
                             out_rd, out_rs1);
                end
            end
            @(negedge CLK);
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_full();
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_vld  = 1'b1;
            in_inst = v_inst[i];
            in_pc   = XLEN'(32'h2000 + 4 * i);
            #1;
            n_checks++;
            if (in_rdy !== (i < 4)) begin
                n_fail++;
                $display("FAIL full_rdy[%0d]: got %b, want %b", i, in_rdy, (i < 4));
            end
            @(negedge CLK);
        end
        in_vld = 1'b0;
        n_checks++;
        if ({count, in_rdy} !== {CW'(4), 1'b0}) begin
            n_fail++;
            $display("FAIL full_count: got count=%0d rdy=%b, want 4/0", count, in_rdy);
        end
        out_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_checks++;
            if ({out_vld, out_pc} !== {1'b1, XLEN'(32'h2000 + 4 * j)}) begin
                n_fail++;
                $display("FAIL pop_order[%0d]: got vld=%b pc=%h, want 1/%h", j, out_vld,
                         out_pc, 32'h2000 + 4 * j);
            end
            @(negedge CLK);
            n_checks++;
            if ({count, in_rdy} !== {CW'(3 - j), 1'b1}) begin
                n_fail++;
                $display("FAIL drain_count[%0d]: got %0d/%b, want %0d/1", j, count, in_rdy,
                         3 - j);
            end
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            in_vld  = 1'b1;
            in_inst = 32'h0050_0093;
            in_pc   = XLEN'(32'h3000 + 4 * i);
            @(negedge CLK);
        end
        in_pc = XLEN'(32'h3F00);
        flush = 1'b1;
        #1;
        n_checks++;
        if ({in_rdy, count} !== {1'b0, CW'(3)}) begin
            n_fail++;
            $display("FAIL flush_rdy: got rdy=%b count=%0d, want 0/3", in_rdy, count);
        end
        @(negedge CLK);
        flush  = 1'b0;
        in_vld = 1'b0;
        n_checks++;
        if ({out_vld, count} !== {1'b0, CW'(0)}) begin
            n_fail++;
            $display("FAIL flush_clear: got vld=%b count=%0d, want 0/0", out_vld, count);
        end
        in_vld = 1'b1;
        in_pc  = XLEN'(32'h4000);
        @(negedge CLK);
        in_vld = 1'b0;
        n_checks++;
        if ({count, out_pc} !== {CW'(1), XLEN'(32'h4000)}) begin
            n_fail++;
            $display("FAIL post_flush_push: got count=%0d pc=%h, want 1/4000", count, out_pc);
        end
        out_rdy = 1'b1;
        @(negedge CLK);
        out_rdy = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            in_vld  = 1'b1;
            in_inst = v_inst[i + 1];
            in_pc   = XLEN'(32'h5000 + 4 * i);
            @(negedge CLK);
        end
        in_vld = 1'b0;
        @(posedge CLK);
        #2;
        RSTN = 1'b0;
        #1;
        n_checks++;
        if ({out_vld, in_rdy, count} !== {1'b0, 1'b1, CW'(0)} || obs !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got vld=%b rdy=%b count=%0d outs=%h, want 0/1/0/0",
                     out_vld, in_rdy, count, obs);
        end
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
    endtask

`ifdef DEC_ILLEGAL_CHK_EN
    task automatic test_illegal();
        logic [31:0] ins [3] = '{32'h0000_007F, 32'h0050_0093, 32'h0220_81B3};
        logic [3:0]  exp [3] = '{4'b1000, 4'b0101, 4'b1000};
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_vld  = 1'b1;
            in_inst = ins[k];
            in_pc   = XLEN'(32'h6000 + 4 * k);
            @(negedge CLK);
            in_vld = 1'b0;
            n_checks++;
            if ({out_illegal, out_rs1_ren, out_rs2_ren, out_rd_wen} !== exp[k]) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got ill/en %b%b%b%b, want %b", k, out_illegal,
                         out_rs1_ren, out_rs2_ren, out_rd_wen, exp[k]);
            end
            @(negedge CLK);
        end
        out_rdy = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [XLEN+31:0] e;
        logic             exp_push, exp_pop;
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            out_rdy = (c < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            in_inst = rand_inst();
            in_pc   = XLEN'($urandom());
            #1;
            exp_push = in_vld && (model_q.size() < DEPTH) && !flush;
            exp_pop  = (model_q.size() > 0) && out_rdy && !flush;
            n_checks++;
            if ({count, out_vld, in_rdy} !==
                {CW'(model_q.size()), model_q.size() != 0,
                 (model_q.size() != DEPTH) && !flush}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got count=%0d vld=%b rdy=%b, want count=%0d",
                         c, count, out_vld, in_rdy, model_q.size());
            end
            if (model_q.size() != 0) begin
                e = model_q[0];
                n_checks++;
                if (obs !== ref_bundle(e[XLEN+31:32], e[31:0])) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got %h, want %h", c, obs,
                             ref_bundle(e[XLEN+31:32], e[31:0]));
                end
            end
            @(posedge CLK);
            if (flush) begin
                model_q.delete();
            end else begin
                if (exp_pop) void'(model_q.pop_front());
                if (exp_push) model_q.push_back({in_pc, in_inst});
            end
            @(negedge CLK);
        end
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_full();
        test_flush();
        test_async_reset();
`ifdef DEC_ILLEGAL_CHK_EN
        test_illegal();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
